branch_cmp_stage: RTL

- Parametrised, registered successor to the ID-stage branch comparator.
- Evaluates an extended set of branch conditions (signed and unsigned, one- and two-operand) on WIDTH-bit operands.
- Latches the decision in a one-entry pipeline register with stall/flush control.
- Flags mispredicts against a supplied static prediction, so the branch outcome can be consumed at the ID/EX boundary.

---
 rtl/branch_cmp_stage.sv | 98 +++++++++
 1 files changed

// File: rtl/branch_cmp_stage.sv
// Registered branch comparator: decodes a branch condition, latches it for one cycle and
// flags a mispredict against the static prediction. Define BRCMP_STATS_EN for retire counters.
module branch_cmp_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             stall,
  input  logic             flush,
  input  logic [3:0]       cmp_mode,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  input  logic             pred_taken,
  output logic             out_valid,
  output logic             branch,
  output logic             mispredict,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  logic [WIDTH:0] diff;
  logic           eq, ltu, lts, a_neg, a_zero, cond;
  logic           out_valid_q, branch_q, pred_q;

  // Zero-extended subtraction: the carry-out bit is the unsigned borrow, the low bits give equality.
  assign diff   = {1'b0, num1} - {1'b0, num2};
  assign eq     = (diff[WIDTH-1:0] == '0);
  assign ltu    = diff[WIDTH];
  assign lts    = $signed(num1) < $signed(num2);
  assign a_neg  = num1[WIDTH-1];
  assign a_zero = (num1 == '0);

  always_comb begin
    cond = 1'b0;
    case (cmp_mode)
      4'd0:    cond = 1'b0;
      4'd1:    cond = eq;
      4'd2:    cond = ~eq;
      4'd3:    cond = ~a_neg & ~a_zero;
      4'd4:    cond = ~a_neg;
      4'd5:    cond = a_neg;
      4'd6:    cond = a_neg | a_zero;
      4'd7:    cond = ~lts;
      4'd8:    cond = lts;
      4'd9:    cond = ltu;
      4'd10:   cond = ~ltu;
      4'd11:   cond = 1'b1;
      default: cond = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      branch_q    <= 1'b0;
      pred_q      <= 1'b0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
      branch_q    <= 1'b0;
      pred_q      <= 1'b0;
    end else if (!stall) begin
      out_valid_q <= in_valid;
      branch_q    <= in_valid & cond;
      pred_q      <= in_valid & pred_taken;
    end
  end

  assign out_valid  = out_valid_q;
  assign branch     = branch_q;
  assign mispredict = out_valid_q & (branch_q ^ pred_q);

`ifdef BRCMP_STATS_EN
  logic [CNT_W-1:0] taken_q, mispred_q;
  logic             retire;

  // A result retires when it leaves the register without being flushed.
  assign retire = out_valid_q & ~stall & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taken_q   <= '0;
      mispred_q <= '0;
    end else if (retire) begin
      if (branch_q && (taken_q != '1))     taken_q   <= taken_q + CNT_W'(1);
      if (mispredict && (mispred_q != '1)) mispred_q <= mispred_q + CNT_W'(1);
    end
  end

  assign taken_cnt   = taken_q;
  assign mispred_cnt = mispred_q;
`else
  assign taken_cnt   = '0;
  assign mispred_cnt = '0;
`endif

endmodule
